cache_axi_master: RTL

- AXI4 burst master sitting directly downstream of the data cache controller FSM.
- Turns the controller's level-held line-fill request (start_read) and write-back request (start_write) into single INCR bursts on the memory-side AXI4 bus.
- Returns an assembled cache line plus a one-cycle completion pulse: r_last for fills, b_resp for write-backs.

---
 rtl/cache_axi_master_if.sv | 62 ++++++
 rtl/cache_axi_master.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cache_axi_master_if.sv
// Memory-side AXI4 bus between the cache burst master and the memory slave.
// Carries the five AXI channels; clock and reset stay outside.
interface cache_axi_master_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32
);
   logic              ar_valid;
   logic              ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;

   logic              r_valid;
   logic              r_ready;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic [1:0]        r_resp;

   logic              aw_valid;
   logic              aw_ready;
   logic [ADDR_W-1:0] aw_addr;
   logic [7:0]        aw_len;
   logic [2:0]        aw_size;
   logic [1:0]        aw_burst;

   logic                w_valid;
   logic                w_ready;
   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic                w_last;

   logic              b_valid;
   logic              b_ready;
   logic [1:0]        b_resp;

   modport master (
      output ar_valid, ar_addr, ar_len, ar_size, ar_burst,
      input  ar_ready,
      input  r_valid, r_data, r_last, r_resp,
      output r_ready,
      output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid, b_resp,
      output b_ready
   );

   modport slave (
      input  ar_valid, ar_addr, ar_len, ar_size, ar_burst,
      output ar_ready,
      output r_valid, r_data, r_last, r_resp,
      input  r_ready,
      input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid, b_resp,
      input  b_ready
   );
endinterface

// File: rtl/cache_axi_master.sv
// AXI4 burst master for the data cache: one INCR burst per line fill or write-back,
// returning the assembled line with a one-cycle completion pulse.
module cache_axi_master #(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 32,
   parameter int BLOCK_WORDS = 16
) (
   input  logic                          clk,
   input  logic                          arst,
   input  logic                          i_start_read,
   input  logic                          i_start_write,
   input  logic [ADDR_W-1:0]             i_addr,
   input  logic [BLOCK_WORDS*DATA_W-1:0] i_wdata_block,
   output logic [BLOCK_WORDS*DATA_W-1:0] o_rdata_block,
   output logic                          o_r_last,
   output logic                          o_b_resp,
   output logic                          o_resp_err,
   cache_axi_master_if.master            axi
);

   localparam int OFF   = $clog2(BLOCK_WORDS * DATA_W / 8);
   localparam int CNT_W = $clog2(BLOCK_WORDS);
   localparam logic [CNT_W-1:0]  LEN        = CNT_W'(BLOCK_WORDS - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;

   state_t                        state;
   logic [ADDR_W-1:0]             addr_q;
   logic [BLOCK_WORDS*DATA_W-1:0] wblk;
   logic [CNT_W-1:0]              rcnt;
   logic [CNT_W-1:0]              wcnt;
   logic                          err_acc;
   logic                          aw_done;
   logic                          w_done;

   logic r_hs, r_beat_err, aw_hs, w_hs, aw_fin, w_fin;

   assign r_hs       = axi.r_valid & axi.r_ready;
   assign r_beat_err = (axi.r_resp != 2'b00) | (axi.r_last != (rcnt == LEN));
   assign aw_hs      = axi.aw_valid & axi.aw_ready;
   assign w_hs       = axi.w_valid & axi.w_ready;
   // AW and the final W beat may land in the same cycle, or AW may trail all W beats.
   assign aw_fin     = aw_done | aw_hs;
   assign w_fin      = w_done | (w_hs & (wcnt == LEN));

   assign axi.ar_addr  = addr_q;
   assign axi.ar_len   = 8'(BLOCK_WORDS - 1);
   assign axi.ar_size  = 3'($clog2(DATA_W / 8));
   assign axi.ar_burst = 2'b01;
   assign axi.aw_addr  = addr_q;
   assign axi.aw_len   = 8'(BLOCK_WORDS - 1);
   assign axi.aw_size  = 3'($clog2(DATA_W / 8));
   assign axi.aw_burst = 2'b01;
   assign axi.w_data   = wblk[int'(wcnt)*DATA_W +: DATA_W];
   assign axi.w_strb   = '1;
   assign axi.w_last   = (wcnt == LEN);

   // Request payload is captured once at accept so the bus payload stays stable.
   always_ff @(posedge clk) begin
      if (state == IDLE && (i_start_write || i_start_read))
         addr_q <= i_addr & ALIGN_MASK;
      if (state == IDLE && i_start_write)
         wblk <= i_wdata_block;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state         <= IDLE;
         axi.ar_valid  <= 1'b0;
         axi.r_ready   <= 1'b0;
         axi.aw_valid  <= 1'b0;
         axi.w_valid   <= 1'b0;
         axi.b_ready   <= 1'b0;
         o_r_last      <= 1'b0;
         o_b_resp      <= 1'b0;
         o_resp_err    <= 1'b0;
         o_rdata_block <= '0;
         rcnt          <= '0;
         wcnt          <= '0;
         err_acc       <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start_write) begin
                  state        <= WR;
                  axi.aw_valid <= 1'b1;
                  axi.w_valid  <= 1'b1;
                  wcnt         <= '0;
                  aw_done      <= 1'b0;
                  w_done       <= 1'b0;
                  err_acc      <= 1'b0;
               end else if (i_start_read) begin
                  state        <= RD_ADDR;
                  axi.ar_valid <= 1'b1;
                  rcnt         <= '0;
                  err_acc      <= 1'b0;
               end
            end
            RD_ADDR: begin
               if (axi.ar_ready) begin
                  axi.ar_valid <= 1'b0;
                  axi.r_ready  <= 1'b1;
                  state        <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (r_hs) begin
                  o_rdata_block[int'(rcnt)*DATA_W +: DATA_W] <= axi.r_data;
                  rcnt    <= rcnt + 1'b1;
                  err_acc <= err_acc | r_beat_err;
                  if (rcnt == LEN) begin
                     axi.r_ready <= 1'b0;
                     o_r_last    <= 1'b1;
                     o_resp_err  <= err_acc | r_beat_err;
                     state       <= DONE;
                  end
               end
            end
            WR: begin
               if (aw_hs) begin
                  axi.aw_valid <= 1'b0;
                  aw_done      <= 1'b1;
               end
               if (w_hs) begin
                  wcnt <= wcnt + 1'b1;
                  if (wcnt == LEN) begin
                     axi.w_valid <= 1'b0;
                     w_done      <= 1'b1;
                  end
               end
               if (aw_fin && w_fin) begin
                  axi.b_ready <= 1'b1;
                  state       <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (axi.b_valid) begin
                  axi.b_ready <= 1'b0;
                  o_b_resp    <= 1'b1;
                  o_resp_err  <= err_acc | (axi.b_resp != 2'b00);
                  state       <= DONE;
               end
            end
            DONE: begin
               // Requests are still held high here; returning to IDLE without sampling them
               // prevents a duplicate burst.
               o_r_last   <= 1'b0;
               o_b_resp   <= 1'b0;
               o_resp_err <= 1'b0;
               aw_done    <= 1'b0;
               w_done     <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
